serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  second operand, captured on accepted start.
REQ-007 SHALL have port cin  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result of a+b+cin modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; the full-adder bit cell, carry flip-flop and bit counter are internal.
REQ-013 IDLE with start=1 at edge E0: capture a, b into shift registers, carry register <= cin, counter <= 0, state <= RUN, busy <= 1.
REQ-014 IDLE with start=0: no state change; busy=0.
REQ-015 RUN, each edge: compute bit sum = a_lsb^b_lsb^carry, carry <= (a_lsb&b_lsb)|((a_lsb^b_lsb)&carry), shift both operand registers right one, shift the sum bit in at MSB of the partial-sum register, counter += 1.
REQ-016 LSB processed first; exactly WIDTH RUN edges (E1..E_WIDTH) per operation.
REQ-017 At edge E_WIDTH: sum <= completed partial sum, cout <= final carry, done <= 1, busy <= 0, state <= IDLE.
REQ-018 done SHALL be high for exactly one cycle (the cycle after E_WIDTH), then 0.
REQ-019 sum and cout SHALL hold the last completed result unchanged until the next completion; they SHALL not show intermediate values.
REQ-020 start while busy=1 SHALL be ignored; a/b/cin changes during RUN SHALL not affect the result.
REQ-021 start=1 in the same cycle done=1 (state IDLE) SHALL be accepted; back-to-back throughput = one result per WIDTH+1 cycles.
REQ-022 Counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL not wrap within an operation.

Reset
REQ-023 rst=1 at any edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, clearing all shift registers (plus ovf=0 when configured).
REQ-024 rst asserted during RUN SHALL abort the operation; no done pulse SHALL follow; rst has priority over start.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add output port ovf  output  1  registered two's-complement overflow flag.
REQ-026 With SERIAL_ADDER_OVF_EN: ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), updated only at E_WIDTH, held otherwise.
REQ-027 Without SERIAL_ADDER_OVF_EN: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 Reset then idle 5 cycles -> busy=0, done=0, sum=0x00, cout=0 throughout.
REQ-029 start with a=0x35, b=0x4A, cin=0 -> done pulses one cycle 8 edges after start edge; sum=0x7F, cout=0; ovf=0.
REQ-030 a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; ovf=0; then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-031 start pulsed again at cycles 3 and 5 of RUN with different operands -> ignored; first result unchanged; start on done cycle -> second op accepted, done again 9 cycles after first done.
REQ-032 rst asserted at RUN cycle 4 -> busy=0 next cycle, no done pulse, sum/cout=0; subsequent start a=0x10, b=0x20 -> sum=0x30.
REQ-033 Random 1000 operand triples, back-to-back -> every sum/cout matches a+b+cin reference model; done count equals accepted start count.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. It computes a + b + cin modulo 2^WIDTH one bit per
// clock, LSB first, using a single full-adder cell and a carry flip-flop.
// Each operation takes WIDTH RUN cycles. The registered result (sum, cout)
// changes only when an operation completes.
//
// Handshake: start is a request that is sampled only while the FSM is in IDLE,
// which is exactly when busy is 0. A start seen while busy is 1 is dropped, not
// queued. When start is accepted, a/b/cin are captured and busy goes high on
// the next cycle. done is a one-cycle pulse in the first IDLE cycle after the
// last bit. A start in that same cycle is accepted, so back-to-back operations
// produce one result every WIDTH+1 cycles.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    sole clock, rising edge
//   rst    synchronous active-high reset; aborts any operation in progress
//   start  request to begin an addition (sampled in IDLE only)
//   a, b   operands, captured on accepted start
//   cin    carry-in, captured on accepted start
//   busy   high while an addition is in progress (FSM is in RUN)
//   done   single-cycle result-valid pulse
//   sum    registered result, held until the next completion
//   cout   registered carry out of bit WIDTH-1
//   ovf    (only with SERIAL_ADDER_OVF_EN) registered two's-complement
//          overflow flag, updated at completion
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output and its logic.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The counter has to hold the values 0..WIDTH-1 during an operation.
  // Sizing it for WIDTH+1 values guarantees that cnt+1 never wraps.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             bit_sum;
  logic             carry_nxt;
  logic [WIDTH-1:0] ps_nxt;

  // Full-adder cell acting on the current LSBs of the shift registers.
  always_comb begin
    bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    carry_nxt = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    ps_nxt    = {bit_sum, ps[WIDTH-1:1]};
  end

  // Next-state logic. accept and last are the two FSM transition events.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        ps    <= '0;
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        ps    <= ps_nxt;
        carry <= carry_nxt;
        cnt   <= cnt + CW'(1);
        if (last) begin
          // The output registers are loaded only here, so intermediate
          // partial sums are never visible on sum/cout.
          sum  <= ps_nxt;
          cout <= carry_nxt;
          done <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last bit, the carry register holds the carry into the
          // MSB and carry_nxt is the carry out of the MSB.
          ovf  <= carry ^ carry_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder at WIDTH=8. It also runs a randomized
// back-to-back run, checked against an a+b+cin reference model through an
// expected-value queue. Each scenario task applies its own stimulus and does
// its own checks. The single summary line reports errors against total checks.
// Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int LIMIT = 40;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  // Expected entries are packed as {ovf, cout, sum}.
  logic [WIDTH+1:0] exp_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Hold start high across one edge, then drop it.
  task automatic drive_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    step();
    start = 1'b0;
  endtask

  // Count edges until done is seen. The wait is bounded by lim.
  task automatic wait_done(input int lim, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < lim) begin
      step();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
                 i, busy, done, sum, cout);
      end
    end
  endtask

  // Run one directed operation and check its latency, result and single-cycle done pulse.
  task automatic directed_op(input string name, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic cv,
                             input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    bit seen;
    drive_start(av, bv, cv);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy got %b want 1", name, busy);
    end
    wait_done(LIMIT, n, seen);
    checks++;
    if (!seen || n != WIDTH) begin
      errors++;
      $display("FAIL %s_latency got seen=%0d edges=%0d want edges=%0d", name, seen, n, WIDTH);
    end
    checks++;
    if (sum !== es || cout !== ec || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_result got sum=%h cout=%b busy=%b want sum=%h cout=%b busy=0",
               name, sum, cout, busy, es, ec);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== eo) begin
      errors++;
      $display("FAIL %s_ovf got %b want %b", name, ovf, eo);
    end
`else
    if (eo) begin end
`endif
    step();
    checks++;
    if (done !== 1'b0 || sum !== es || cout !== ec) begin
      errors++;
      $display("FAIL %s_hold got done=%b sum=%h cout=%b want done=0 sum=%h cout=%b",
               name, done, sum, cout, es, ec);
    end
  endtask

  task automatic test_basic();
    directed_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
  endtask

  task automatic test_carry_ovf();
    directed_op("add_ff_01_c1", 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    directed_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_start();
    int  i;
    int  n;
    bit  seen;
    drive_start(8'h12, 8'h34, 1'b0);   // expected sum 0x46
    i    = 0;
    seen = 1'b0;
    while (!seen && i < LIMIT) begin
      // Start pulses and operand changes during RUN must not be accepted.
      start = (i == 2 || i == 4);
      a     = 8'hAA + 8'(i);
      b     = 8'hBB;
      cin   = 1'b1;
      step();
      i++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || i != WIDTH || sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got seen=%0d edges=%0d sum=%h cout=%b want edges=8 sum=46 cout=0",
               seen, i, sum, cout);
    end
    // Start presented in the done cycle has to be accepted.
    drive_start(8'h01, 8'h02, 1'b1);  // expected sum 0x04
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle_accept got busy=%b want 1", busy);
    end
    step();
    step();
    checks++;
    if (sum !== 8'h46) begin
      errors++;
      $display("FAIL no_intermediate got sum=%h want 46", sum);
    end
    wait_done(LIMIT, n, seen);
    checks++;
    if (!seen || n + 3 != WIDTH + 1 || sum !== 8'h04 || cout !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_second got seen=%0d gap=%0d sum=%h cout=%b want gap=9 sum=04 cout=0",
               seen, n + 3, sum, cout);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int dones;
    drive_start(8'h55, 8'h22, 1'b0);
    step();
    step();
    step();
    rst   = 1'b1;
    start = 1'b1;   // reset has priority over start
    step();
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b sum=%h cout=%b want 0/0/00/0",
               busy, done, sum, cout);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", dones);
    end
    directed_op("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int               accepted;
    int               dones;
    int               n;
    bit               seen;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             cv;
    logic [WIDTH:0]   full;
    logic             eo;
    logic [WIDTH+1:0] exp_v;
    accepted = 0;
    dones    = 0;
    for (int j = 0; j < 1000; j++) begin
      av   = WIDTH'($urandom_range(0, 255));
      bv   = WIDTH'($urandom_range(0, 255));
      cv   = 1'($urandom_range(0, 1));
      full = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
      eo   = (av[WIDTH-1] == bv[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
      exp_q.push_back({eo, full});
      drive_start(av, bv, cv);
      accepted++;
      wait_done(LIMIT, n, seen);
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout op=%0d", j);
        break;
      end
      dones++;
      exp_v = exp_q.pop_front();
      checks++;
      if (n != WIDTH || {cout, sum} !== exp_v[WIDTH:0]
`ifdef SERIAL_ADDER_OVF_EN
          || ovf !== exp_v[WIDTH+1]
`endif
         ) begin
        errors++;
        $display("FAIL rand_op op=%0d a=%h b=%h cin=%b got edges=%0d cout=%b sum=%h want edges=%0d cout=%b sum=%h",
                 j, av, bv, cv, n, cout, sum, WIDTH, exp_v[WIDTH], exp_v[WIDTH-1:0]);
      end
    end
    checks++;
    if (dones != accepted || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_count got dones=%0d pending=%0d want dones=%0d pending=0",
               dones, exp_q.size(), accepted);
    end
    step();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_carry_ovf();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
